// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the program loader: FSM state encoding,
// error codes reported on err_code, stream byte width and the default frame
// start marker.
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 12;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_PAD  = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    WORD,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // Length field is 12 bits; only the low nibble of LEN_HI is meaningful.
  function automatic logic [LEN_W-1:0] frame_len(input logic [3:0] hi,
                                                 input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Valid/ready byte stream feeding the program loader.
//   in_data  : stream byte
//   in_valid : in_data valid (held by the source until accepted)
//   in_ready : sink accepts a byte; transfer on in_valid && in_ready at clk rise
// master = byte source, slave = loader.
// ---------------------------------------------------------------------------
interface program_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects three big-endian bytes into one instruction word.
//   clk, rst      : clock, async active-low reset
//   clear         : synchronous clear of byte index and shift register
//   byte_en       : a data byte is accepted this cycle
//   byte_data     : the accepted byte
//   word          : assembled word (complete the cycle after word_complete)
//   word_complete : byte_en on the third byte of a word
//   pad_err       : byte_en on the first byte with nonzero bits [7:3]
// ---------------------------------------------------------------------------
module word_assembler
  import loader_pkg::*;
#(
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_complete,
  output logic               pad_err
);

  logic [1:0]         byte_idx;
  logic [INSTR_W-1:0] shift_q;

  assign word          = shift_q;
  assign word_complete = byte_en && (byte_idx == 2'd2);
  assign pad_err       = byte_en && (byte_idx == 2'd0) && (byte_data[7:3] != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (byte_en) begin
      if (byte_idx == 2'd0) begin
        // First byte only carries the top three instruction bits.
        shift_q  <= {{(INSTR_W-3){1'b0}}, byte_data[2:0]};
        byte_idx <= 2'd1;
      end else begin
        shift_q  <= {shift_q[INSTR_W-BYTE_W-1:0], byte_data};
        byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Loads a framed program image from a byte stream into instruction memory
// and releases the core from reset once the image checksum verifies.
// Frame: SYNC, LEN_HI, LEN_LO, LEN x (3 bytes, big-endian), CSUM.
//
// Ports:
//   clk, rst    : clock, async active-low reset
//   in_bus      : valid/ready byte stream (slave side)
//   reload      : restart request, honoured only in DONE or ERROR
//   imem_we     : one-cycle write strobe
//   imem_addr   : write address, sequential from 0
//   imem_wdata  : write data
//   core_rst    : active-low core reset, released after a good load
//   done, error : load outcome
//   err_code    : 01 bad length, 10 bad pad bits, 11 checksum, 00 none
//
// state  | meaning
// IDLE   | hunting for SYNC, other bytes dropped
// LEN_HI | expecting length high nibble
// LEN_LO | expecting length low byte
// WORD   | receiving instruction bytes
// WRITE  | one-cycle memory write, stream stalled
// CSUM   | expecting checksum byte
// DONE   | load good, core released
// ERROR  | load aborted, core held
// ---------------------------------------------------------------------------
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter int         INSTR_W   = 19,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  program_loader_if.slave     in_bus,
  input  logic                reload,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                core_rst,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code
);

  state_t            state;
  logic              in_ready_q;
  logic [3:0]        len_hi_q;
  logic [LEN_W-1:0]  word_cnt;
  logic [BYTE_W-1:0] csum_acc;

  logic              xfer;
  logic              sync_hit;
  logic              reload_hit;
  logic              asm_clear;
  logic              asm_en;
  logic              word_complete;
  logic              pad_err;
  logic [LEN_W-1:0]  len_now;

  assign in_bus.in_ready = in_ready_q;

  assign xfer       = in_bus.in_valid && in_ready_q;
  assign sync_hit   = (state == IDLE) && xfer && (in_bus.in_data == SYNC_BYTE);
  assign reload_hit = reload && ((state == DONE) || (state == ERROR));
  assign asm_clear  = sync_hit || reload_hit;
  assign asm_en     = (state == WORD) && xfer;
  assign len_now    = frame_len(len_hi_q, in_bus.in_data);

  // The assembler's shift register is a flop that holds the finished word
  // throughout the WRITE cycle, so it drives imem_wdata directly.
  word_assembler #(
    .INSTR_W (INSTR_W)
  ) u_word_assembler (
    .clk           (clk),
    .rst           (rst),
    .clear         (asm_clear),
    .byte_en       (asm_en),
    .byte_data     (in_bus.in_data),
    .word          (imem_wdata),
    .word_complete (word_complete),
    .pad_err       (pad_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      len_hi_q   <= 4'd0;
      word_cnt   <= '0;
      csum_acc   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      core_rst   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_hit) begin
            state     <= LEN_HI;
            csum_acc  <= '0;
            imem_addr <= '0;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            csum_acc <= csum_acc ^ in_bus.in_data;
            if (in_bus.in_data[7:4] != 4'd0) begin
              state      <= ERROR;
              in_ready_q <= 1'b0;
              error      <= 1'b1;
              err_code   <= ERR_LEN;
            end else begin
              len_hi_q <= in_bus.in_data[3:0];
              state    <= LEN_LO;
            end
          end
        end

        LEN_LO: begin
          if (xfer) begin
            csum_acc <= csum_acc ^ in_bus.in_data;
            word_cnt <= len_now;
            state    <= (len_now == '0) ? CSUM : WORD;
          end
        end

        WORD: begin
          if (xfer) begin
            csum_acc <= csum_acc ^ in_bus.in_data;
            if (pad_err) begin
              state      <= ERROR;
              in_ready_q <= 1'b0;
              error      <= 1'b1;
              err_code   <= ERR_PAD;
            end else if (word_complete) begin
              state      <= WRITE;
              in_ready_q <= 1'b0;
              imem_we    <= 1'b1;
            end
          end
        end

        WRITE: begin
          imem_addr  <= imem_addr + ADDR_W'(1);
          word_cnt   <= word_cnt - LEN_W'(1);
          in_ready_q <= 1'b1;
          // word_cnt still counts the word being written here.
          state      <= (word_cnt == LEN_W'(1)) ? CSUM : WORD;
        end

        CSUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_bus.in_data == csum_acc) begin
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b1;
            end else begin
              state    <= ERROR;
              error    <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end

        DONE: begin
          if (reload) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            done       <= 1'b0;
            core_rst   <= 1'b0;
          end
        end

        ERROR: begin
          if (reload) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reload = 1'b0;
  always #5 clk = ~clk;

  program_loader_if bus();

  logic        imem_we;
  logic [11:0] imem_addr;
  logic [18:0] imem_wdata;
  logic        core_rst, done, error;
  logic [1:0]  err_code;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_bus     (bus),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  typedef struct {
    logic [11:0] addr;
    logic [18:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [4:0] exp_end[$];   // {done, error, err_code, core_rst}
  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [4:0] END_DONE = 5'b10001;
  localparam logic [4:0] END_LEN  = 5'b01010;
  localparam logic [4:0] END_PAD  = 5'b01100;
  localparam logic [4:0] END_CSUM = 5'b01110;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and load outcomes as the DUT presents them.
  initial begin
    logic       prev_end;
    wr_t        e;
    logic [4:0] ee;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(imem_addr), 64'(e.addr));
          check("wr_data", 64'(imem_wdata), 64'(e.data));
          check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
        end
      end
      if ((done === 1'b1 || error === 1'b1) && !prev_end) begin
        if (exp_end.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_end: status %b, expected none", {done, error, err_code, core_rst});
        end else begin
          ee = exp_end.pop_front();
          check("end_status", 64'({done, error, err_code, core_rst}), 64'(ee));
        end
      end
      prev_end = (done === 1'b1) || (error === 1'b1);
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h in_ready %b expected 1", b, bus.in_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int max_gap);
    foreach (f[i]) send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reload(input string name);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check(name, 64'({done, error, err_code, core_rst, bus.in_ready}), 64'b000001);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_addr_data"}, 64'({imem_addr, imem_wdata}), 64'd0);
    check({name, "_flags"}, 64'({imem_we, core_rst, done, error, err_code, bus.in_ready}), 64'b0000001);
  endtask

  task automatic push_nominal_writes();
    wr_t w;
    w.addr = 12'd0; w.data = 19'h12345; exp_wr.push_back(w);
    w.addr = 12'd1; w.data = 19'h7FFFF; exp_wr.push_back(w);
  endtask

  logic [7:0] frame[$];

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Nominal load, continuous valid
    frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
    push_nominal_writes();
    exp_end.push_back(END_DONE);
    send_frame(frame, 0);
    check("done_latency", 64'({done, core_rst, bus.in_ready}), 64'b110);
    repeat (2) @(negedge clk);
    do_reload("reload_after_done");

    // Garbage then zero-length frame
    frame = {8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
    exp_end.push_back(END_DONE);
    send_frame(frame, 0);
    check("zero_len_done", 64'({done, err_code}), 64'b100);
    repeat (2) @(negedge clk);
    do_reload("reload_after_zero");

    // Bad pad bits in first byte of a word
    frame = {8'hA5, 8'h00, 8'h01, 8'h08};
    exp_end.push_back(END_PAD);
    send_frame(frame, 0);
    repeat (3) @(negedge clk);
    check("pad_core_held", 64'({core_rst, imem_we}), 64'd0);
    do_reload("reload_after_pad");
    frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
    push_nominal_writes();
    exp_end.push_back(END_DONE);
    send_frame(frame, 0);
    repeat (2) @(negedge clk);
    do_reload("reload_after_recover");

    // Bad length
    frame = {8'hA5, 8'h10};
    exp_end.push_back(END_LEN);
    send_frame(frame, 0);
    repeat (2) @(negedge clk);
    do_reload("reload_after_len");

    // Checksum mismatch after both writes
    frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h63};
    push_nominal_writes();
    exp_end.push_back(END_CSUM);
    send_frame(frame, 0);
    repeat (2) @(negedge clk);
    do_reload("reload_after_csum");

    // Nominal load with random valid gaps
    frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
    push_nominal_writes();
    exp_end.push_back(END_DONE);
    send_frame(frame, 3);
    repeat (2) @(negedge clk);
    do_reload("reload_after_gaps");

    // Async reset mid-frame, then a clean load from address 0
    frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23};
    send_frame(frame, 0);
    #2 rst = 1'b0;
    #1 check_reset_vals("midframe_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    frame = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
    push_nominal_writes();
    exp_end.push_back(END_DONE);
    send_frame(frame, 0);
    check("post_reset_done", 64'({done, core_rst}), 64'b11);

    repeat (5) @(negedge clk);
    check("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    check("ends_outstanding", 64'(exp_end.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer that fills the instruction memory the core fetches from.
- Receives a framed program image over a valid/ready byte interface and assembles 19-bit instruction words.
- Issues one write per word at sequential addresses from 0 and verifies an XOR checksum.
- Holds the core in reset via core_rst until a load completes without error.

Parameters:
- ADDR_W, 12, instruction-memory address width (matches the PC).
- INSTR_W, 19, instruction word width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready on the rising clk edge.
- reload  input  1  single-cycle request to restart loading; sampled only in DONE or ERROR.
- imem_we  output  1  instruction-memory write strobe, single cycle.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  INSTR_W  write data.
- core_rst  output  1  active-low reset to the core; 0 while loading.
- done  output  1  load finished with correct checksum.
- error  output  1  load aborted.
- err_code  output  2  01 bad length, 10 bad pad bits, 11 checksum mismatch, 00 none.

Behaviour:
- Frame format: SYNC, LEN_HI, LEN_LO, then LEN words of 3 bytes each (big-endian), then CSUM. LEN = {LEN_HI[3:0], LEN_LO}.
- Reset: async clear of all state. State=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, error=0, err_code=00, word count=0, checksum accumulator=0. Writes already committed to memory are not undone.
- All outputs are registered.
- States and transitions:
  - IDLE: in_ready=1. Any accepted byte other than SYNC_BYTE is discarded. SYNC -> LEN_HI, clear accumulator and address.
  - LEN_HI: in_ready=1. Accepted byte with [7:4]!=0 -> ERROR, err_code 01; otherwise -> LEN_LO.
  - LEN_LO: in_ready=1. LEN==0 -> CSUM; else -> WORD, byte index=0.
  - WORD: in_ready=1. Byte 0 supplies bits [18:16] from [2:0]; byte0[7:3]!=0 -> ERROR, err_code 10, and no write for that word. After byte 2 -> WRITE.
  - WRITE: in_ready=0. imem_we=1 for exactly this cycle with the current imem_addr and imem_wdata. Then imem_addr increments. If the remaining count is 0 -> CSUM, else -> WORD.
  - CSUM: in_ready=1. Accepted byte == XOR of LEN_HI, LEN_LO and all data bytes -> DONE; otherwise -> ERROR, err_code 11.
  - DONE: in_ready=0, done=1, core_rst=1 from the first DONE cycle. reload -> IDLE: done=0, core_rst=0 on the next cycle.
  - ERROR: in_ready=0, error=1, core_rst stays 0. reload -> IDLE, clearing error and err_code.
- The accumulator XORs every accepted byte after SYNC, excluding the CSUM byte itself.
- Address wrap cannot occur because LEN <= 4095.
- in_valid may stay high while in_ready=0; the byte is held by the source and is accepted later.
- reload outside DONE/ERROR is ignored.
- Asynchronous reset mid-frame aborts the frame immediately; the next load must restart from SYNC.
- Load latency: one WRITE cycle per word beyond the byte transfers; done rises the cycle after the CSUM byte is accepted.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, WORD, WRITE, CSUM, DONE, ERROR).
  - err_code constants ERR_NONE, ERR_LEN, ERR_PAD, ERR_CSUM.
  - SYNC_BYTE default.
- Sub-module word_assembler:
  - Contains the 2-bit byte index and the 19-bit shift register.
  - Flags a pad violation and signals word_complete.
  - Cleared by the FSM on SYNC and on reload.

Test Plan:
- Nominal load: stream A5 00 02 01 23 45 07 FF FF 62 with in_valid continuous -> two writes, addr 0 = 0x12345 and addr 1 = 0x7FFFF; in_ready low in each WRITE cycle; done=1 and core_rst=1 the cycle after 62 is accepted.
- Garbage then zero length: 00 FF 3C A5 00 00 00 -> no imem_we; done=1, err_code 00.
- Bad pad: A5 00 01 08 00 00 -> ERROR, err_code 10, no write, core_rst stays 0; reload pulse then a valid frame -> done.
- Bad length and checksum:
  - A5 10 -> err_code 01.
  - Nominal frame with CSUM 63 -> err_code 11 after both writes occur.
- Backpressure and reset:
  - Random in_valid gaps -> same writes as the nominal load.
  - rst low after the 2nd data byte -> all outputs return to reset values immediately.
  - Subsequent frame loads correctly from addr 0.
